// File: rtl/proc_pkg.sv
// Shared fetch-stage types and constants.
package proc_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam logic [INSTR_W-1:0] PC_INC   = 32'd4;
   localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0100_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] target;
      logic               annul;
   } redirect_t;

endpackage

// File: rtl/pc_npc_reg.sv
// SPARC-style PC/nPC pair with its next-value mux (sequential, annulled, delayed).
module pc_npc_reg
   import proc_pkg::*;
#(
   parameter int unsigned         PC_W     = INSTR_W,
   parameter logic [PC_W-1:0]     RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_advance,
   input  logic            i_redirect,
   input  logic            i_annul,
   input  logic [PC_W-1:0] i_target,
   output logic [PC_W-1:0] o_pc,
   output logic [PC_W-1:0] o_npc
);

   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_npc;
   logic [PC_W-1:0] w_pc_nxt;
   logic [PC_W-1:0] w_npc_nxt;

   always_comb begin
      w_pc_nxt  = r_pc;
      w_npc_nxt = r_npc;
      if (i_advance) begin
         if (i_redirect && i_annul) begin
            w_pc_nxt  = i_target;
            w_npc_nxt = i_target + PC_W'(PC_INC);
         end else if (i_redirect) begin
            w_pc_nxt  = r_npc;
            w_npc_nxt = i_target;
         end else begin
            w_pc_nxt  = r_npc;
            w_npc_nxt = r_npc + PC_W'(PC_INC);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc  <= RESET_PC;
         r_npc <= RESET_PC + PC_W'(PC_INC);
      end else begin
         r_pc  <= w_pc_nxt;
         r_npc <= w_npc_nxt;
      end
   end

   assign o_pc  = r_pc;
   assign o_npc = r_npc;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: boot/run/pending-redirect FSM, redirect latch and IR handshake.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises a sticky trap and freezes fetch.
module fetch_unit
   import proc_pkg::*;
#(
   parameter int unsigned     PC_W     = INSTR_W,
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            Clk,
   input  logic            Reset,
   output logic [PC_W-1:0] FetchAddress,
   input  logic [PC_W-1:0] Instruction,
   input  logic            Redirect,
   input  logic [PC_W-1:0] RedirectTarget,
   input  logic            Annul,
   output logic [PC_W-1:0] IR,
   output logic [PC_W-1:0] IRPC,
   output logic            IRValid,
   input  logic            DecodeReady,
   output logic            MisalignTrap
);

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;
   redirect_t       r_pend;
   redirect_t       w_eff;
   logic [PC_W-1:0] r_ir;
   logic [PC_W-1:0] r_irpc;
   logic            r_ir_valid;
   logic [PC_W-1:0] w_pc;
   logic [PC_W-1:0] w_npc;
   logic [PC_W-1:0] w_live_tgt;
   logic            w_latch;
   logic            w_advance;
   logic            w_eff_redir;
   logic            w_bad;
   logic            w_frozen;
   logic            w_take;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic r_trap;

   assign w_live_tgt = RedirectTarget;
   assign w_bad      = w_eff_redir && (w_eff.target[1:0] != 2'b00);
   assign w_frozen   = r_trap;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         r_trap <= 1'b0;
      else if (w_advance && w_bad)
         r_trap <= 1'b1;
   end

   assign MisalignTrap = r_trap;
`else
   assign w_live_tgt   = RedirectTarget & ~PC_W'(3);
   assign w_bad        = 1'b0;
   assign w_frozen     = 1'b0;
   assign MisalignTrap = 1'b0;
`endif

   // A live redirect always beats the latched one.
   assign w_eff_redir = Redirect || (r_state == PEND);
   assign w_eff       = Redirect ? redirect_t'{target: w_live_tgt, annul: Annul} : r_pend;
   assign w_advance   = (r_state != BOOT) && (!r_ir_valid || DecodeReady) && !w_frozen;
   assign w_take      = w_advance && !w_bad;

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      unique case (r_state)
         BOOT: begin
            w_state_nxt = Redirect ? PEND : RUN;
            w_latch     = Redirect;
         end
         RUN: begin
            if (Redirect && !w_advance) begin
               w_state_nxt = PEND;
               w_latch     = 1'b1;
            end
         end
         PEND: begin
            if (w_advance)
               w_state_nxt = RUN;
            else
               w_latch = Redirect;
         end
         default: w_state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= BOOT;
         r_pend  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch)
            r_pend <= redirect_t'{target: w_live_tgt, annul: Annul};
      end
   end

   pc_npc_reg #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) u_pc_npc_reg (
      .clk        (Clk),
      .rst_n      (Reset),
      .i_advance  (w_take),
      .i_redirect (w_eff_redir),
      .i_annul    (w_eff.annul),
      .i_target   (w_eff.target),
      .o_pc       (w_pc),
      .o_npc      (w_npc)
   );

   // Instruction register; a rejected redirect drops IRValid instead of capturing.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_ir       <= '0;
         r_irpc     <= '0;
         r_ir_valid <= 1'b0;
      end else if (w_take) begin
         r_ir       <= Instruction;
         r_irpc     <= w_pc;
         r_ir_valid <= 1'b1;
      end else if (w_advance || ((r_state == BOOT) && DecodeReady)) begin
         r_ir_valid <= 1'b0;
      end
   end

   assign FetchAddress = w_pc;
   assign IR           = r_ir;
   assign IRPC         = r_irpc;
   assign IRValid      = r_ir_valid;

   logic w_unused;
   assign w_unused = ^w_npc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus random traffic vs. a reference model.
module tb_fetch_unit;
   import proc_pkg::*;

   logic        Clk   = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] FetchAddress;
   logic [31:0] Instruction;
   logic        Redirect;
   logic [31:0] RedirectTarget;
   logic        Annul;
   logic [31:0] IR;
   logic [31:0] IRPC;
   logic        IRValid;
   logic        DecodeReady;
   logic        MisalignTrap;

   logic [31:0] mem_xor = 32'h0;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 Clk = ~Clk;

   assign Instruction = FetchAddress ^ mem_xor;

   fetch_unit dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .FetchAddress   (FetchAddress),
      .Instruction    (Instruction),
      .Redirect       (Redirect),
      .RedirectTarget (RedirectTarget),
      .Annul          (Annul),
      .IR             (IR),
      .IRPC           (IRPC),
      .IRValid        (IRValid),
      .DecodeReady    (DecodeReady),
      .MisalignTrap   (MisalignTrap)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: architectural PC/nPC, IR, an optional pending redirect.
   logic [31:0] m_pc, m_npc, m_ir, m_irpc, m_pend_t;
   logic        m_v, m_boot, m_pend_v, m_pend_a, m_trap;

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         m_pc     <= 32'h0;
         m_npc    <= 32'h4;
         m_ir     <= 32'h0;
         m_irpc   <= 32'h0;
         m_v      <= 1'b0;
         m_boot   <= 1'b1;
         m_pend_v <= 1'b0;
         m_pend_t <= 32'h0;
         m_pend_a <= 1'b0;
         m_trap   <= 1'b0;
      end else begin : step
         logic        adv, have_r, a, bad;
         logic [31:0] t, lt;
`ifdef FETCH_MISALIGN_TRAP_EN
         lt = RedirectTarget;
`else
         lt = RedirectTarget & 32'hFFFF_FFFC;
`endif
         adv    = !m_boot && (!m_v || DecodeReady) && !m_trap;
         have_r = Redirect || m_pend_v;
         t      = Redirect ? lt : m_pend_t;
         a      = Redirect ? Annul : m_pend_a;
         bad    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         bad    = have_r && (t[1:0] != 2'b00);
`endif
         if (m_boot) begin
            m_boot <= 1'b0;
            if (Redirect) begin
               m_pend_v <= 1'b1;
               m_pend_t <= lt;
               m_pend_a <= Annul;
            end
            if (DecodeReady) m_v <= 1'b0;
         end else if (adv && bad) begin
            m_trap <= 1'b1;
            m_v    <= 1'b0;
         end else if (adv) begin
            m_ir     <= m_pc ^ mem_xor;
            m_irpc   <= m_pc;
            m_v      <= 1'b1;
            m_pend_v <= 1'b0;
            if (!have_r) begin
               m_pc  <= m_npc;
               m_npc <= m_npc + 32'd4;
            end else if (a) begin
               m_pc  <= t;
               m_npc <= t + 32'd4;
            end else begin
               m_pc  <= m_npc;
               m_npc <= t;
            end
         end else if (Redirect) begin
            m_pend_v <= 1'b1;
            m_pend_t <= lt;
            m_pend_a <= Annul;
         end
      end
   end

   always @(negedge Clk) begin
      if (!$isunknown(m_pc)) begin
         chk("m_fetch_addr", FetchAddress, m_pc);
         chk("m_ir", IR, m_ir);
         chk("m_irpc", IRPC, m_irpc);
         chk("m_irvalid", 32'(IRValid), 32'(m_v));
         chk("m_trap", 32'(MisalignTrap), 32'(m_trap));
      end
   end

   task automatic cyc();
      @(negedge Clk);
      #1;
   endtask

   initial begin
      Redirect       = 1'b0;
      RedirectTarget = 32'h0;
      Annul          = 1'b0;
      DecodeReady    = 1'b1;
      #1 Reset = 1'b0;
      cyc();
      cyc();
      chk("rst_fetch_addr", FetchAddress, 32'h0);
      chk("rst_ir", IR, 32'h0);
      chk("rst_ir_not_nop", 32'(IR == NOP_WORD), 32'h0);
      chk("rst_irpc", IRPC, 32'h0);
      chk("rst_irvalid", 32'(IRValid), 32'h0);
      chk("rst_trap", 32'(MisalignTrap), 32'h0);
      Reset = 1'b1;

      // Sequential fetch out of reset, address-as-data memory
      cyc();
      chk("boot_irvalid", 32'(IRValid), 32'h0);
      chk("boot_fetch_addr", FetchAddress, 32'h0);
      cyc();
      chk("seq_irvalid", 32'(IRValid), 32'h1);
      chk("seq_irpc0", IRPC, 32'h0);
      chk("seq_ir0", IR, 32'h0);
      cyc();
      chk("seq_irpc4", IRPC, 32'h4);
      chk("seq_ir4", IR, 32'h4);
      cyc();
      chk("seq_irpc8", IRPC, 32'h8);
      chk("seq_fetch_c", FetchAddress, 32'hC);

      // Decode stall holds everything
      DecodeReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_irpc", IRPC, 32'h8);
         chk("stall_ir", IR, 32'h8);
         chk("stall_fetch", FetchAddress, 32'hC);
      end
      DecodeReady = 1'b1;
      cyc();
      chk("resume_irpc", IRPC, 32'hC);
      chk("resume_fetch", FetchAddress, 32'h10);

      // Delayed redirect, delay slot executes
      Redirect = 1'b1; RedirectTarget = 32'h100; Annul = 1'b0;
      cyc();
      Redirect = 1'b0;
      chk("dly_irpc_10", IRPC, 32'h10);
      cyc();
      chk("dly_irpc_14", IRPC, 32'h14);
      cyc();
      chk("dly_irpc_100", IRPC, 32'h100);
      cyc();
      chk("dly_irpc_104", IRPC, 32'h104);

      // Annulled redirect back to 0x10, then annulled redirect to 0x100
      Redirect = 1'b1; RedirectTarget = 32'h10; Annul = 1'b1;
      cyc();
      chk("ann_pre_fetch", FetchAddress, 32'h10);
      RedirectTarget = 32'h100;
      cyc();
      Redirect = 1'b0;
      chk("ann_irpc_10", IRPC, 32'h10);
      chk("ann_fetch_100", FetchAddress, 32'h100);
      cyc();
      chk("ann_irpc_100", IRPC, 32'h100);
      cyc();
      chk("ann_irpc_104", IRPC, 32'h104);

      // Redirect during stall, overwritten while pending
      DecodeReady = 1'b0;
      Redirect = 1'b1; RedirectTarget = 32'h200; Annul = 1'b1;
      cyc();
      chk("pend_irpc_hold", IRPC, 32'h104);
      RedirectTarget = 32'h300;
      cyc();
      Redirect = 1'b0;
      cyc();
      chk("pend_fetch_hold", FetchAddress, 32'h108);
      DecodeReady = 1'b1;
      cyc();
      chk("pend_irpc_108", IRPC, 32'h108);
      chk("pend_fetch_300", FetchAddress, 32'h300);
      cyc();
      chk("pend_irpc_300", IRPC, 32'h300);

      // Reset while a redirect is pending
      DecodeReady = 1'b0;
      Redirect = 1'b1; RedirectTarget = 32'h400; Annul = 1'b1;
      cyc();
      Redirect = 1'b0;
      Reset = 1'b0;
      #1;
      chk("mid_rst_fetch", FetchAddress, 32'h0);
      chk("mid_rst_irvalid", 32'(IRValid), 32'h0);
      chk("mid_rst_irpc", IRPC, 32'h0);
      chk("mid_rst_ir", IR, 32'h0);
      Reset = 1'b1;
      DecodeReady = 1'b1;
      cyc();
      chk("mid_rst_boot", 32'(IRValid), 32'h0);
      cyc();
      chk("mid_rst_irpc0", IRPC, 32'h0);
      chk("mid_rst_fetch4", FetchAddress, 32'h4);
      cyc();
      chk("mid_rst_irpc4", IRPC, 32'h4);

`ifdef FETCH_MISALIGN_TRAP_EN
      Redirect = 1'b1; RedirectTarget = 32'h102; Annul = 1'b1;
      cyc();
      Redirect = 1'b0;
      chk("mis_trap", 32'(MisalignTrap), 32'h1);
      chk("mis_irvalid", 32'(IRValid), 32'h0);
      cyc();
      chk("mis_sticky", 32'(MisalignTrap), 32'h1);
`endif

      Reset = 1'b0;
      #1 Reset = 1'b1;

      // Random traffic against the model
      mem_xor = $urandom;
      for (int i = 0; i < 3000; i++) begin
         cyc();
         #1;
         Redirect       = ($urandom % 100) < 15;
         RedirectTarget = $urandom & ((($urandom % 16) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         Annul          = 1'($urandom % 2);
         DecodeReady    = ($urandom % 100) < 70;
         Reset          = !(($urandom % 400) == 0);
      end
      Reset = 1'b1;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
